// File: rtl/mux2_pkt_arbiter_pkg.sv
// Shared state encodings and beat-counter sizing for mux2_pkt_arbiter.
package mux2_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

  // Counter must hold 0..max_beats; never narrower than one bit.
  function automatic int cnt_width(input int max_beats);
    int w;
    w = $clog2(max_beats + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux2_pkt_arbiter_mux2_bus.sv
// Parameterised WIDTH-bit 2:1 combinational select: y = s ? d1 : d0.
module mux2_bus #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux2_pkt_arbiter.sv
// Two-requester packet arbiter owning a shared 2:1 mux; grant held per packet.
// Build option MUX2ARB_FIXED_PRIO_EN: port 0 wins contention instead of round-robin.
//
// state    | meaning
// ST_IDLE  | no owner, nothing accepted, SEL holds its last value
// ST_BUSY0 | port 0 owns the mux until its LAST (or forced) beat is accepted
// ST_BUSY1 | port 1 owns the mux until its LAST (or forced) beat is accepted
module mux2_pkt_arbiter
  import mux2_pkt_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             VALID0,
  input  logic             VALID1,
  input  logic             LAST0,
  input  logic             LAST1,
  output logic             READY0,
  output logic             READY1,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic             O_LAST,
  input  logic             O_READY,
  output logic             SEL,
  output logic             BUSY,
  output logic             OVR
);

  localparam int            CW        = cnt_width(MAX_BEATS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_FORCE = CW'(MAX_BEATS - 1);

  state_e        state, state_nxt;
  logic          sel_q, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_gnt, last_nxt;
  logic          ovr_q, ovr_nxt;

  logic          o_last_w;
  logic          own_valid, oth_valid;
  logic          accept, forced, rel;
  logic          handover, idle_pick;

  mux2_bus #(.WIDTH(WIDTH)) u_data_mux (.s(sel_q), .d0(I0), .d1(I1), .y(O));
  mux2_bus #(.WIDTH(1))     u_last_mux (.s(sel_q), .d0(LAST0), .d1(LAST1), .y(o_last_w));

  // sel_q always matches the owner while busy, so it also picks the owner's VALID.
  assign own_valid = sel_q ? VALID1 : VALID0;
  assign oth_valid = sel_q ? VALID0 : VALID1;
  assign accept    = BUSY && own_valid && O_READY;
  assign forced    = (MAX_BEATS != 0) && accept && !o_last_w && (cnt == CNT_FORCE);
  assign rel       = accept && (o_last_w || forced);

`ifdef MUX2ARB_FIXED_PRIO_EN
  assign handover  = sel_q ? VALID0 : (VALID1 && !VALID0);
  assign idle_pick = !VALID0;
`else
  assign handover  = oth_valid;
  assign idle_pick = (VALID0 && VALID1) ? !last_gnt : VALID1;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt;
    last_nxt  = last_gnt;
    ovr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (VALID0 || VALID1) begin
          state_nxt = idle_pick ? ST_BUSY1 : ST_BUSY0;
          sel_nxt   = idle_pick;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (rel) begin
          last_nxt = sel_q;
          ovr_nxt  = forced;
          cnt_nxt  = '0;
          if (handover) begin
            state_nxt = sel_q ? ST_BUSY0 : ST_BUSY1;
            sel_nxt   = !sel_q;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (accept && cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state    <= ST_IDLE;
      sel_q    <= 1'b0;
      cnt      <= '0;
      last_gnt <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_nxt;
      ovr_q    <= ovr_nxt;
    end
  end

  assign BUSY    = (state != ST_IDLE);
  assign READY0  = (state == ST_BUSY0) && O_READY;
  assign READY1  = (state == ST_BUSY1) && O_READY;
  assign O_VALID = BUSY && own_valid;
  assign O_LAST  = o_last_w;
  assign SEL     = sel_q;
  assign OVR     = ovr_q;

endmodule

// File: tb/tb_mux2_pkt_arbiter.sv
// Self-checking bench for mux2_pkt_arbiter: directed vector table, corner sequences, random vs model.
module tb_mux2_pkt_arbiter;

  localparam int MAXB = 16;

  logic       clk, rst;
  logic [7:0] i0, i1, o_data;
  logic       valid0, valid1, last0, last1, o_ready;
  logic       ready0, ready1, o_valid, o_last, sel, busy, ovr;

  mux2_pkt_arbiter #(.WIDTH(8), .MAX_BEATS(MAXB)) dut (
    .C(clk), .R(rst), .I0(i0), .I1(i1),
    .VALID0(valid0), .VALID1(valid1), .LAST0(last0), .LAST1(last1),
    .READY0(ready0), .READY1(ready1), .O(o_data), .O_VALID(o_valid),
    .O_LAST(o_last), .O_READY(o_ready), .SEL(sel), .BUSY(busy), .OVR(ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner -1 means nobody holds the grant.
  int m_owner, m_last, m_beats;
  bit m_sel, m_ovr;
  bit model_on = 0;

  logic [14:0] probe;
  int ovr_cnt = 0;
  bit ovr_sel = 0;
  int acc1 = 0;

  typedef struct {
    logic       rst, v0, v1, l0, l1, ordy;
    logic [7:0] d0, d1;
    logic [6:0] e_ctl;   // {ready0, ready1, o_valid, o_last, sel, busy, ovr}
    logic [7:0] e_o;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {ready0, ready1, o_valid, o_last, sel, busy, ovr, o_data};
  endfunction

  function automatic logic [14:0] model_vec();
    logic ov;
    ov = (m_owner == 0) ? valid0 : (m_owner == 1) ? valid1 : 1'b0;
    return {(m_owner == 0) && o_ready, (m_owner == 1) && o_ready, ov,
            m_sel ? last1 : last0, m_sel, m_owner >= 0, m_ovr, m_sel ? i1 : i0};
  endfunction

  task automatic grant(input int p);
    m_owner = p;
    m_sel   = (p == 1);
    m_beats = 0;
  endtask

  task automatic model_step();
    bit v[2];
    bit l[2];
    int n;
    bit forced, nxt_ovr;
    v[0] = valid0; v[1] = valid1;
    l[0] = last0;  l[1] = last1;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_beats = 0; m_last = 1; m_ovr = 0;
    end else begin
      nxt_ovr = 0;
      if (m_owner < 0) begin
        if (v[0] && v[1]) begin
`ifdef MUX2ARB_FIXED_PRIO_EN
          grant(0);
`else
          grant(m_last == 0 ? 1 : 0);
`endif
        end else if (v[0]) grant(0);
        else if (v[1]) grant(1);
      end else begin
        n = m_owner;
        if (v[n] && o_ready) begin
          m_beats++;
          forced = (MAXB != 0) && (m_beats == MAXB) && !l[n];
          if (l[n] || forced) begin
            m_last  = n;
            nxt_ovr = forced;
`ifdef MUX2ARB_FIXED_PRIO_EN
            if (n == 1 ? v[0] : (v[1] && !v[0])) grant(1 - n);
`else
            if (v[1 - n]) grant(1 - n);
`endif
            else m_owner = -1;
          end
        end
      end
      m_ovr = nxt_ovr;
    end
  endtask

  task automatic tick(input bit tbl, input logic [14:0] texp, input string tname);
    @(negedge clk);
    probe = dut_vec();
    if (ovr) begin
      ovr_cnt++;
      ovr_sel = sel;
    end
    if (valid1 && ready1) acc1++;
    if (model_on) chk("model", probe, model_vec());
    if (tbl) chk(tname, probe, texp);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; valid0 = 0; valid1 = 0; last0 = 0; last1 = 0; o_ready = 1;
    tick(0, '0, "");
    rst = 0;
  endtask

  initial begin
    i0 = 0; i1 = 0;
    do_reset();
    do_reset();
    model_on = 1;

    // 3-beat port-0 packet, reset, then contention alternating 0,1,0,1.
    vecs[0]  = '{0,1,0,0,0,1, 8'h11, 8'h00, 7'b0000000, 8'h11};
    vecs[1]  = '{0,1,0,0,0,1, 8'h12, 8'h00, 7'b1010010, 8'h12};
    vecs[2]  = '{0,1,0,0,0,1, 8'h13, 8'h00, 7'b1010010, 8'h13};
    vecs[3]  = '{0,1,0,1,0,1, 8'h14, 8'h00, 7'b1011010, 8'h14};
    vecs[4]  = '{0,0,0,0,0,1, 8'h15, 8'h00, 7'b0000000, 8'h15};
    vecs[5]  = '{1,0,0,0,0,1, 8'h00, 8'h00, 7'b0000000, 8'h00};
    vecs[6]  = '{0,1,1,0,0,1, 8'h21, 8'h31, 7'b0000000, 8'h21};
    vecs[7]  = '{0,1,1,0,0,1, 8'h22, 8'h32, 7'b1010010, 8'h22};
    vecs[8]  = '{0,1,1,1,0,1, 8'h23, 8'h33, 7'b1011010, 8'h23};
    vecs[9]  = '{0,1,1,0,0,1, 8'h24, 8'h34, 7'b0110110, 8'h34};
    vecs[10] = '{0,1,1,0,1,1, 8'h25, 8'h35, 7'b0111110, 8'h35};
    vecs[11] = '{0,1,1,0,0,1, 8'h26, 8'h36, 7'b1010010, 8'h26};
    vecs[12] = '{0,1,1,1,0,1, 8'h27, 8'h37, 7'b1011010, 8'h27};
    vecs[13] = '{0,1,1,0,0,1, 8'h28, 8'h38, 7'b0110110, 8'h38};
    vecs[14] = '{0,1,1,0,1,1, 8'h29, 8'h39, 7'b0111110, 8'h39};
    vecs[15] = '{0,0,0,0,0,1, 8'h2a, 8'h3a, 7'b1000010, 8'h2a};
    for (int r = 0; r < 16; r++) begin
      rst = vecs[r].rst; valid0 = vecs[r].v0; valid1 = vecs[r].v1;
      last0 = vecs[r].l0; last1 = vecs[r].l1; o_ready = vecs[r].ordy;
      i0 = vecs[r].d0; i1 = vecs[r].d1;
      tick(1, {vecs[r].e_ctl, vecs[r].e_o}, $sformatf("vec%0d", r));
    end
    rst = 0;

    // Port 1 stalled mid-packet for 4 cycles; no beat lost.
    do_reset();
    acc1 = 0;
    valid1 = 1; last1 = 0; o_ready = 1;
    tick(0, '0, "");
    tick(0, '0, "");
    o_ready = 0;
    repeat (4) begin
      tick(0, '0, "");
      chk("stall_hold", {probe[13], probe[10], probe[9]}, 3'b011);
    end
    o_ready = 1;
    tick(0, '0, "");
    last1 = 1;
    tick(0, '0, "");
    valid1 = 0; last1 = 0;
    tick(0, '0, "");
    chk("stall_beats", acc1, 3);
    chk("stall_idle", probe[9], 0);

    // Port 0 streams without LAST while port 1 waits: forced release after 16 beats.
    do_reset();
    ovr_cnt = 0;
    valid0 = 1; valid1 = 1; last0 = 0; last1 = 0;
    repeat (22) tick(0, '0, "");
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_owner", ovr_sel, 1);

    // Reset in the middle of a port-1 packet.
    do_reset();
    valid1 = 1;
    tick(0, '0, "");
    tick(0, '0, "");
    rst = 1;
    tick(0, '0, "");
    rst = 0; valid0 = 0; valid1 = 0;
    tick(0, '0, "");
    chk("rst_idle", {probe[14], probe[13], probe[10], probe[9]}, 4'b0000);
    valid0 = 1; valid1 = 1;
    tick(0, '0, "");
    tick(0, '0, "");
    chk("rst_first", {probe[10], probe[9]}, 2'b01);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(63) == 0);
      valid0  = ($urandom_range(9) < 7);
      valid1  = ($urandom_range(9) < 7);
      last0   = ($urandom_range(9) < 2);
      last1   = ($urandom_range(9) < 3);
      o_ready = ($urandom_range(9) < 8);
      i0      = 8'($urandom);
      i1      = 8'($urandom);
      tick(0, '0, "");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_pkt_arbiter.md
Name: mux2_pkt_arbiter

Overview:
Two-requester packet arbiter that shares one WIDTH-bit 2:1 select mux (F7-style) between two valid/ready streams. It owns the mux select register and decides which input drives the shared output. The grant is held for a whole packet, from grant until the LAST beat is accepted, and alternates round-robin between requesters. It sits in front of any single-consumer resource fed by two producers.

Parameters:
WIDTH, 8, data bus width of I0/I1/O
MAX_BEATS, 16, forced-release beat limit per grant; 0 disables the limit

Ports:
C  input  1  clock, all state on rising edge
R  input  1  synchronous active-high reset
I0  input  WIDTH  data from requester 0
I1  input  WIDTH  data from requester 1
VALID0  input  1  requester 0 beat valid
VALID1  input  1  requester 1 beat valid
LAST0  input  1  requester 0 final beat of packet
LAST1  input  1  requester 1 final beat of packet
READY0  output  1  beat accepted from requester 0 when VALID0 && READY0
READY1  output  1  beat accepted from requester 1 when VALID1 && READY1
O  output  WIDTH  muxed data, SEL ? I1 : I0
O_VALID  output  1  output beat valid
O_LAST  output  1  muxed LAST
O_READY  input  1  downstream accepts beat
SEL  output  1  registered mux select / current owner
BUSY  output  1  a grant is active
OVR  output  1  one-cycle pulse when MAX_BEATS forced a release

Behaviour:
- Clock and reset: one clock C; reset R is synchronous and active-high.
- States: IDLE, BUSY0, BUSY1. BUSY = (state != IDLE). SEL is registered: 0 in BUSY0, 1 in BUSY1, holds its last value in IDLE.
- Reset (also mid-packet): state IDLE, SEL=0, beat counter 0, OVR=0, last-granted pointer=1 so port 0 wins first. Combinationally this gives READY0=READY1=O_VALID=0. Any in-flight packet is abandoned with no further beats.
- IDLE: no beats accepted. If only one VALID is high, that port is granted. If both are high, the port != last-granted wins. Transition at the next edge, with SEL updated on the same edge. Minimum latency from VALID to first acceptance is 1 cycle.
- BUSYn: O_VALID=VALIDn, O_LAST=LASTn, READYn=O_READY, other READY=0. O and O_LAST are purely combinational through the mux. A beat is accepted when VALIDn && O_READY.
- Release on accepted beat with LASTn=1, or on a forced release.
  - On release, last-granted is set to n.
  - Next state is BUSY(other) if VALID(other)=1 in the release cycle (zero-bubble handover). Otherwise it is IDLE.
  - The same port is never regranted directly from release; it must pass through IDLE.
- Beat counter: cleared on each grant, incremented on each accepted beat, saturates at MAX_BEATS.
- Forced release: if MAX_BEATS != 0 and the accepted beat is number MAX_BEATS without LAST, force release. OVR pulses high in the cycle after that beat. The requester's remaining beats are treated as a new packet.
- A VALID dropping mid-packet is legal: the grant is held and O_VALID follows VALIDn.
- An O_READY stall holds all state.

Optional Feature:
MUX2ARB_FIXED_PRIO_EN
- Defined: port 0 always wins a simultaneous request in IDLE and at handover. At release of port 1, handover goes to port 0 if VALID0, otherwise to IDLE. The last-granted pointer is unused.
- Undefined: round-robin as described above.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_BUSY0=2'd1, ST_BUSY1=2'd2
  - the beat-counter width function clog2(MAX_BEATS+1), minimum 1
- One natural sub-module: mux2_bus, a parameterised WIDTH-bit 2:1 combinational mux (O = S ? I1 : I0), instantiated for the data and for LAST.

Test Plan:
- Reset then VALID0=1 with 3-beat packet (LAST on beat 3), O_READY=1 -> grant next cycle, SEL=0, O=I0 on three beats, IDLE after the third, BUSY=0.
- VALID0=VALID1=1 from reset, 2-beat packets each -> port 0 served first, then port 1 with no idle cycle; SEL toggles 0->1 at the release edge. Repeat -> order 0,1,0,1.
- Port 1 granted, O_READY=0 for 4 cycles mid-packet -> READY1=0, SEL=1, counter and state frozen; resumes without beat loss.
- MAX_BEATS=16, port 0 sends 20 beats without LAST while VALID1=1 -> after beat 16, OVR pulses once, grant moves to port 1.
- R asserted during beat 2 of a port-1 packet -> next cycle IDLE, SEL=0, READY0=READY1=0. Subsequent simultaneous request -> port 0 wins.
- With MUX2ARB_FIXED_PRIO_EN, both ports continuously requesting 1-beat packets -> port 1 granted only when VALID0=0 at a release.
